// File: rtl/peripherals_top.sv
// Peripheral top: ADC sampling, mV / degC conversion, 3-digit 7-segment display, LED bar and fan PWM.
// Fan PWM logic is built only when PWM_FAN_EN is defined; otherwise pwm_out is tied low.
module peripherals_top #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int PWM_BITS      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  switches,
  input  logic        button,
  input  logic [11:0] adc_value,
  output logic [9:0]  leds,
  output logic [7:0]  display0,
  output logic [7:0]  display1,
  output logic [7:0]  display2,
  output logic        pwm_out
);

  localparam int TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              tick_d;
  logic [11:0]       sample;
  logic              mode_r;
  logic [12:0]       mv;
  logic [10:0]       temp;
  logic [9:0]        mv_div10;
  logic [9:0]        disp_value;
  logic              btn_meta;
  logic              btn_sync;
  logic [5:0]        led_n;
  logic [9:0]        led_bar;
  conv_state_t       conv_state;
  logic [3:0]        conv_cnt;
  logic [9:0]        conv_bin;
  logic [11:0]       conv_bcd;
  logic [11:0]       bcd_adj;
  logic              conv_mode;
  logic              unused_switches;

  assign unused_switches = ^switches[9:1];

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick = (tick_cnt == TICK_W'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Display mode is captured with the sample so a mid-period switch flip waits for the next tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample <= '0;
      mode_r <= 1'b1;
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick;
      if (tick) begin
        sample <= adc_value;
        mode_r <= switches[0];
      end
    end
  end

  assign mv         = {1'b0, sample} + {3'b000, sample[11:2]};
  assign temp       = mv[12:2];
  assign mv_div10   = 10'(mv / 13'd10);
  assign disp_value = mode_r ? ((temp > 11'd999) ? 10'd999 : temp[9:0]) : mv_div10;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
    end
  end

  assign led_n = (temp[10:5] > 6'd10) ? 6'd10 : temp[10:5];

  always_comb begin
    led_bar = '0;
    for (int i = 0; i < 10; i++) begin
      led_bar[i] = (6'(i) < led_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds <= '0;
    end else begin
      leds <= led_bar;
    end
  end

  always_comb begin
    bcd_adj = conv_bcd;
    for (int i = 0; i < 3; i++) begin
      if (conv_bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = conv_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Double-dabble: a new tick always restarts; a result finishing while frozen is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_state <= CONV_IDLE;
      conv_cnt   <= '0;
      conv_bin   <= '0;
      conv_bcd   <= '0;
      conv_mode  <= 1'b1;
      display0   <= 8'hFF;
      display1   <= 8'hFF;
      display2   <= 8'hFF;
    end else begin
      if (tick_d) begin
        conv_bin   <= disp_value;
        conv_bcd   <= '0;
        conv_cnt   <= '0;
        conv_mode  <= mode_r;
        conv_state <= CONV_SHIFT;
      end else begin
        case (conv_state)
          CONV_IDLE: conv_state <= CONV_IDLE;
          CONV_SHIFT: begin
            {conv_bcd, conv_bin} <= 22'({bcd_adj, conv_bin, 1'b0});
            conv_cnt <= conv_cnt + 1'b1;
            if (conv_cnt == 4'd9) begin
              conv_state <= CONV_DONE;
            end
          end
          CONV_DONE: conv_state <= CONV_IDLE;
          default:   conv_state <= CONV_IDLE;
        endcase
      end
      if (conv_state == CONV_DONE && btn_sync) begin
        display2 <= {conv_mode, seg7(conv_bcd[11:8])};
        display1 <= {1'b1, seg7(conv_bcd[7:4])};
        display0 <= {1'b1, seg7(conv_bcd[3:0])};
      end
    end
  end

`ifdef PWM_FAN_EN
  localparam int PWM_MAX = (2 ** PWM_BITS) - 1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;

  // Duty only changes as the counter wraps, so every period is a whole pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
      duty    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) begin
        duty <= (32'(temp) > 32'(PWM_MAX)) ? '1 : PWM_BITS'(temp);
      end
    end
  end

  assign pwm_out = (pwm_cnt < duty);
`else
  localparam int unused_pwm_bits = PWM_BITS;

  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_peripherals_top.sv
// Self-checking bench for peripherals_top: a period-level reference model checked every cycle,
// plus hand-computed display/LED/PWM values for the key operating points.
module tb_peripherals_top;

  localparam int P = 1000;
`ifdef PWM_FAN_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  switches;
  logic        button;
  logic [11:0] adc_value;
  logic [9:0]  leds;
  logic [7:0]  display0, display1, display2;
  logic        pwm_out;

  int checks = 0;
  int errors = 0;

  int          n = 0;
  int          tick_count = 0;
  int          last_tick = -1;
  int          m_sample = 0;
  int          m_duty = 0;
  logic [9:0]  exp_leds = '0;
  logic        exp_pwm = 1'b0;
  logic [7:0]  exp_d0 = 8'hFF, exp_d1 = 8'hFF, exp_d2 = 8'hFF;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  peripherals_top #(.SAMPLE_PERIOD(P), .PWM_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .switches  (switches),
    .button    (button),
    .adc_value (adc_value),
    .leds      (leds),
    .display0  (display0),
    .display1  (display1),
    .display2  (display2),
    .pwm_out   (pwm_out)
  );

  function automatic int mv_of(input int a);
    return a + (a >> 2);
  endfunction

  function automatic int temp_of(input int a);
    return mv_of(a) >> 2;
  endfunction

  function automatic logic [9:0] leds_of(input int a);
    int k;
    k = temp_of(a) >> 5;
    if (k > 10) k = 10;
    return 10'((1 << k) - 1);
  endfunction

  task automatic compute_disp(input int a, input logic mode,
                              output logic [7:0] d2, output logic [7:0] d1, output logic [7:0] d0);
    int t, v;
    t = temp_of(a);
    v = mode ? ((t > 999) ? 999 : t) : (mv_of(a) / 10);
    d2 = {mode, seg_tab[v / 100]};
    d1 = {1'b1, seg_tab[(v / 10) % 10]};
    d0 = {1'b1, seg_tab[v % 10]};
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset release, sample per period, duty per PWM period.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0;
      m_sample = 0;
      m_duty = 0;
      exp_leds = '0;
      exp_pwm = 1'b0;
      exp_d0 = 8'hFF;
      exp_d1 = 8'hFF;
      exp_d2 = 8'hFF;
      last_tick = -1;
    end else begin
      n++;
      exp_leds = leds_of(m_sample);
      if (n % 256 == 0) m_duty = (temp_of(m_sample) > 255) ? 255 : temp_of(m_sample);
      exp_pwm = PWM_EN && ((n % 256) < m_duty);
      if (n % P == 0) begin
        m_sample = int'(adc_value);
        last_tick = n;
        tick_count++;
        if (button) compute_disp(m_sample, switches[0], exp_d2, exp_d1, exp_d0);
      end
    end
  end

  always @(negedge clk) begin
    check_output("leds", 32'(leds), 32'(exp_leds));
    check_output("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    if (last_tick < 0 || n - last_tick >= 16) begin
      check_output("displays", {8'h0, display2, display1, display0}, {8'h0, exp_d2, exp_d1, exp_d0});
    end
  end

  task automatic wait_after_tick(input int d);
    int start;
    int i;
    start = tick_count;
    i = 0;
    while (!(tick_count > start && n - last_tick >= d) && i < 3 * P) begin
      @(negedge clk);
      i++;
    end
    if (i >= 3 * P) begin
      checks++;
      errors++;
      $display("[TB] FAIL tick_timeout: got no tick after %0d cycles, expected one within %0d", i, P);
    end
  endtask

  task automatic apply_stimulus(input int a, input logic mode, input logic btn);
    adc_value = 12'(a);
    switches  = {9'b0, mode};
    button    = btn;
    wait_after_tick(20);
  endtask

  task automatic measure_pwm(output int highs);
    highs = 0;
    repeat (280) @(negedge clk);
    repeat (256) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
  endtask

  initial begin
    int highs;
    int guard;
    switches  = 10'h001;
    button    = 1'b1;
    adc_value = '0;

    repeat (5) @(negedge clk);
    check_output("reset_disp", {8'h0, display2, display1, display0}, 32'hFFFFFF);
    check_output("reset_leds", 32'(leds), 32'h0);
    check_output("reset_pwm", 32'(pwm_out), 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;

    guard = 0;
    while (n < P - 1 && guard < 2 * P) begin
      @(negedge clk);
      guard++;
    end
    check_output("pre_tick_disp", {8'h0, display2, display1, display0}, 32'hFFFFFF);

    wait_after_tick(20);
    check_output("zero_disp", {8'h0, display2, display1, display0}, 32'hC0C0C0);
    check_output("zero_leds", 32'(leds), 32'h0);

    apply_stimulus(819, 1'b1, 1'b1);
    check_output("t255_disp", {8'h0, display2, display1, display0}, 32'hA49292);
    check_output("t255_leds", 32'(leds), 32'h07F);
    measure_pwm(highs);
    check_output("t255_pwm_highs", 32'(highs), PWM_EN ? 32'd255 : 32'd0);

    apply_stimulus(819, 1'b0, 1'b1);
    check_output("v102_disp", {8'h0, display2, display1, display0}, 32'h79C0A4);

    apply_stimulus(3319, 1'b1, 1'b1);
    check_output("sat999_disp", {8'h0, display2, display1, display0}, 32'h909090);
    check_output("sat999_leds", 32'(leds), 32'h3FF);
    measure_pwm(highs);
    check_output("sat999_pwm_highs", 32'(highs), PWM_EN ? 32'd255 : 32'd0);

    apply_stimulus(4095, 1'b0, 1'b1);
    check_output("v511_disp", {8'h0, display2, display1, display0}, 32'h12F9F9);

    for (int k = 0; k < 8; k++) begin
      apply_stimulus(819 + 50 * k, 1'b1, 1'b1);
    end

    apply_stimulus(819, 1'b1, 1'b1);
    apply_stimulus(1219, 1'b1, 1'b0);
    check_output("freeze_disp", {8'h0, display2, display1, display0}, 32'hA49292);
    check_output("freeze_leds", 32'(leds), 32'h3FF);
    apply_stimulus(1219, 1'b1, 1'b1);
    check_output("release_disp", {8'h0, display2, display1, display0}, 32'hB080C0);

    for (int k = 0; k < 10; k++) begin
      apply_stimulus(int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0));
    end

    adc_value = 12'd2000;
    switches  = 10'h001;
    button    = 1'b1;
    wait_after_tick(5);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check_output("midreset_disp", {8'h0, display2, display1, display0}, 32'hFFFFFF);
    check_output("midreset_leds", 32'(leds), 32'h0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    wait_after_tick(20);
    check_output("t625_disp", {8'h0, display2, display1, display0}, 32'h82A492);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
